// File: rtl/count_seq_checker_pkg.sv
// Shared constants for count_seq_checker: sample width, terminal value and FSM state encodings.
package count_seq_checker_pkg;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(0);

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/count_seq_checker_seq_next_val.sv
// Modulo-16 decrement: the value a healthy down-counter should present after cur.
module seq_next_val
    import count_seq_checker_pkg::*;
(
    input  logic [CNT_W-1:0] cur,
    output logic [CNT_W-1:0] prev_c
);

    // 0 rolls over to CNT_MAX through natural wrap of the subtraction
    assign prev_c = cur - CNT_W'(1);

endmodule

// File: rtl/count_seq_checker.sv
// Checks that an upstream 4-bit down-counter steps 15..0 in order; counts completed periods.
// Optional violation counter enabled by defining COUNT_SEQ_CHECKER_ERR_CNT_EN.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned WRAP_W = 8
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
    ,
    parameter int unsigned ERR_W  = 4
`endif
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              cnt_vld,
    input  logic              clr,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err,
    output logic [ST_W-1:0]   state
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0]  err_cnt
`endif
);

    logic [CNT_W-1:0]  exp_q;
    logic [CNT_W-1:0]  exp_nxt;
    logic [CNT_W-1:0]  dec_c;
    logic [ST_W-1:0]   state_nxt;
    logic              tc_nxt;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              err_nxt;
    logic              mismatch_c;

    seq_next_val u_next (
        .cur    (cnt_in),
        .prev_c (dec_c)
    );

    assign mismatch_c = cnt_vld && (state == ST_TRACK) && (cnt_in != exp_q);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            exp_q    <= CNT_MAX;
            tc_pulse <= 1'b0;
            wrap_cnt <= '0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_q    <= exp_nxt;
            tc_pulse <= tc_nxt;
            wrap_cnt <= wrap_nxt;
            seq_err  <= err_nxt;
        end
    end

    // Next-state and output decode; clr overrides any sample in the same cycle
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        tc_nxt    = 1'b0;
        wrap_nxt  = wrap_cnt;
        err_nxt   = seq_err;
        if (clr) begin
            state_nxt = ST_IDLE;
            exp_nxt   = CNT_MAX;
            wrap_nxt  = '0;
            err_nxt   = 1'b0;
        end else if (cnt_vld) begin
            exp_nxt = dec_c;
            case (state)
                ST_IDLE: begin
                    state_nxt = (cnt_in == CNT_MAX) ? ST_TRACK : ST_SYNC;
                end
                ST_SYNC: begin
                    if (cnt_in == CNT_MAX) state_nxt = ST_TRACK;
                end
                ST_TRACK: begin
                    if (cnt_in != exp_q) begin
                        state_nxt = ST_FAULT;
                        err_nxt   = 1'b1;
                    end else if (cnt_in == CNT_MIN) begin
                        tc_nxt   = 1'b1;
                        wrap_nxt = wrap_cnt + WRAP_W'(1);
                    end
                end
                default: begin
                    if (cnt_in == CNT_MAX) state_nxt = ST_TRACK;
                end
            endcase
        end
    end

`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_nxt;

    // Saturating violation counter; only TRACK mismatches count
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (clr) begin
            err_cnt_nxt = '0;
        end else if (mismatch_c && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt_nxt = err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt_nxt;
        end
    end
`else
    logic unused_c;
    assign unused_c = mismatch_c;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: vector table plus hand-written reset/gap/wrap sequences.
module tb_count_seq_checker;

    localparam int unsigned WRAP_W = 8;
    localparam int unsigned ERR_W  = 4;
    localparam int S_IDLE  = 0;
    localparam int S_SYNC  = 1;
    localparam int S_TRACK = 2;
    localparam int S_FAULT = 3;

    typedef struct {
        logic       clr;
        logic       vld;
        logic [3:0] din;
        int         tc;
        int         wrap;
        int         err;
        int         st;
        int         ecnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cnt_in;
    logic              cnt_vld;
    logic              clr;
    logic              tc_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              seq_err;
    logic [1:0]        state;
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
    logic [ERR_W-1:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    count_seq_checker #(
        .WRAP_W(WRAP_W)
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
        ,
        .ERR_W(ERR_W)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .cnt_vld  (cnt_vld),
        .clr      (clr),
        .tc_pulse (tc_pulse),
        .wrap_cnt (wrap_cnt),
        .seq_err  (seq_err),
        .state    (state)
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_ecnt(input string name, input int req);
`ifdef COUNT_SEQ_CHECKER_ERR_CNT_EN
        chk(name, int'(err_cnt), req);
`else
        if (req < 0) $display("note: %s unused", name);
`endif
    endtask

    function automatic void add(input logic c, input logic v, input int d, input int tc,
                                input int wrap, input int err, input int st, input int ecnt);
        vec_t x;
        x.clr = c; x.vld = v; x.din = 4'(d);
        x.tc = tc; x.wrap = wrap; x.err = err; x.st = st; x.ecnt = ecnt;
        vq.push_back(x);
    endfunction

    // Drive one cycle at negedge and sample #1 after the following posedge
    task automatic step(input logic c, input logic v, input int d);
        @(negedge clk);
        clr = c; cnt_vld = v; cnt_in = 4'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int tc, input int wrap, input int err, input int st);
        chk({tag, ".tc"},    int'(tc_pulse), tc);
        chk({tag, ".wrap"},  int'(wrap_cnt), wrap);
        chk({tag, ".err"},   int'(seq_err),  err);
        chk({tag, ".state"}, int'(state),    st);
    endtask

    initial begin
        int fe;
        rst = 1'b0; clr = 1'b0; cnt_vld = 1'b0; cnt_in = 4'd0;

        // Aligned full period, then an idle cycle
        for (int s = 15; s >= 0; s--) add(0, 1, s, (s == 0) ? 1 : 0, (s == 0) ? 1 : 0, 0, S_TRACK, 0);
        add(0, 0, 0, 0, 1, 0, S_TRACK, 0);
        // Skip of 13 faults; 11 stays FAULT without counting; 15 resyncs
        add(1, 1, 5, 0, 0, 0, S_IDLE, 0);
        add(0, 1, 15, 0, 0, 0, S_TRACK, 0);
        add(0, 1, 14, 0, 0, 0, S_TRACK, 0);
        add(0, 1, 12, 0, 0, 1, S_FAULT, 1);
        add(0, 1, 11, 0, 0, 1, S_FAULT, 1);
        for (int s = 15; s >= 0; s--) add(0, 1, s, (s == 0) ? 1 : 0, (s == 0) ? 1 : 0, 1, S_TRACK, 1);
        add(0, 1, 15, 0, 1, 1, S_TRACK, 1);
        add(0, 1, 15, 0, 1, 1, S_FAULT, 2);
        // Unaligned start stays in SYNC until 15
        add(1, 0, 0, 0, 0, 0, S_IDLE, 0);
        add(0, 1, 7, 0, 0, 0, S_SYNC, 0);
        add(0, 1, 6, 0, 0, 0, S_SYNC, 0);
        add(0, 1, 5, 0, 0, 0, S_SYNC, 0);
        for (int s = 15; s >= 0; s--) add(0, 1, s, (s == 0) ? 1 : 0, (s == 0) ? 1 : 0, 0, S_TRACK, 0);
        // clr beats a terminal sample in the same cycle
        add(1, 0, 0, 0, 0, 0, S_IDLE, 0);
        for (int s = 15; s >= 1; s--) add(0, 1, s, 0, 0, 0, S_TRACK, 0);
        add(1, 1, 0, 0, 0, 0, S_IDLE, 0);
        add(0, 1, 3, 0, 0, 0, S_SYNC, 0);
        // Repeated hold faults drive the error counter into saturation
        add(1, 0, 0, 0, 0, 0, S_IDLE, 0);
        add(0, 1, 15, 0, 0, 0, S_TRACK, 0);
        for (int k = 1; k <= 17; k++) begin
            fe = (k > 15) ? 15 : k;
            add(0, 1, 15, 0, 0, 1, S_FAULT, fe);
            add(0, 1, 15, 0, 0, 1, S_TRACK, fe);
        end

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, S_IDLE);
        chk_ecnt("reset.ecnt", 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].clr, vq[i].vld, int'(vq[i].din));
            chk_all($sformatf("vec%0d", i), vq[i].tc, vq[i].wrap, vq[i].err, vq[i].st);
            chk_ecnt($sformatf("vec%0d.ecnt", i), vq[i].ecnt);
        end

        // Two periods with three idle cycles after every sample
        step(1, 0, 0);
        for (int p = 0; p < 2; p++) begin
            for (int s = 15; s >= 0; s--) begin
                step(0, 1, s);
                chk_all($sformatf("gap.p%0d.s%0d", p, s), (s == 0) ? 1 : 0, p + ((s == 0) ? 1 : 0), 0, S_TRACK);
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 0);
                    chk(($sformatf("gap.p%0d.s%0d.idle%0d.tc", p, s, g)), int'(tc_pulse), 0);
                    chk(($sformatf("gap.p%0d.s%0d.idle%0d.st", p, s, g)), int'(state), S_TRACK);
                end
            end
        end
        chk("gap.wrap_final", int'(wrap_cnt), 2);

        // wrap_cnt rolls from all-ones back to zero
        step(1, 0, 0);
        for (int p = 0; p < 256; p++) begin
            for (int s = 15; s >= 0; s--) step(0, 1, s);
            if (p == 254) chk("wrap.255", int'(wrap_cnt), 255);
        end
        chk("wrap.rollover", int'(wrap_cnt), 0);
        chk("wrap.err", int'(seq_err), 0);

        // Asynchronous reset mid-period discards alignment and sticky state
        step(1, 0, 0);
        step(0, 1, 15);
        step(0, 1, 13);
        for (int s = 15; s >= 0; s--) step(0, 1, s);
        for (int s = 15; s >= 8; s--) step(0, 1, s);
        chk_all("prerst", 0, 1, 1, S_TRACK);
        #2;
        rst = 1'b0;
        #1;
        chk_all("asyncrst", 0, 0, 0, S_IDLE);
        chk_ecnt("asyncrst.ecnt", 0);
        @(negedge clk);
        cnt_vld = 1'b1; cnt_in = 4'd15;
        @(posedge clk);
        #1;
        chk("rsthold.state", int'(state), S_IDLE);
        @(negedge clk);
        rst = 1'b1; cnt_vld = 1'b1; cnt_in = 4'd7;
        @(posedge clk);
        #1;
        chk_all("resume7", 0, 0, 0, S_SYNC);
        step(0, 1, 6);
        chk_all("resume6", 0, 0, 0, S_SYNC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter WRAP_W, default 8, width of completed-period counter wrap_cnt.
REQ-002 Parameter ERR_W, default 4, width of error counter err_cnt.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 cnt_in  input  4  down-counter value from upstream stage; bit0 = out0 (LSB) .. bit3 = out3 (MSB).
REQ-006 cnt_vld  input  1  sample strobe; cnt_in evaluated only in cycles with cnt_vld=1.
REQ-007 clr  input  1  synchronous clear of wrap_cnt, seq_err, err_cnt and FSM (to IDLE); highest priority after rst.
REQ-008 tc_pulse  output  1  one-cycle pulse: aligned sample of 0 accepted.
REQ-009 wrap_cnt  output  WRAP_W  count of complete 15->0 periods observed.
REQ-010 seq_err  output  1  sticky flag: sequence violation since last clr/reset.
REQ-011 state  output  2  current FSM state encoding (IDLE=0, SYNC=1, TRACK=2, FAULT=3).
REQ-012 err_cnt  output  ERR_W  violation count; present only with ERR_CNT_EN.

Function
REQ-013 All outputs registered; response to a sample appears the cycle after cnt_vld=1 is sampled (latency 1).
REQ-014 Register expected value exp[3:0]; after each accepted sample exp = sample-1 modulo 16 (0 -> 15).
REQ-015 IDLE: first cnt_vld -> SYNC if sample != 15; -> TRACK if sample == 15; exp loaded from sample.
REQ-016 SYNC: sample == 15 -> TRACK; any other value stays SYNC, no error raised.
REQ-017 TRACK: sample == exp -> stay TRACK; sample != exp -> FAULT, seq_err=1, err_cnt+1.
REQ-018 FAULT: sample == 15 -> TRACK (resync); otherwise stay FAULT, no further err_cnt increments until TRACK re-entered.
REQ-019 tc_pulse=1 for exactly one cycle when TRACK accepts sample 0 matching exp; never in IDLE/SYNC/FAULT.
REQ-020 wrap_cnt increments with each tc_pulse; wraps from all-ones to 0.
REQ-021 err_cnt saturates at all-ones; no wrap.
REQ-022 cnt_vld=0: no state, exp, or output change; tc_pulse=0.
REQ-023 clr and cnt_vld same cycle: clr wins, sample discarded, next state IDLE.
REQ-024 Hold of a value (same value twice, cnt_vld both cycles) in TRACK is a violation.

Reset
REQ-025 rst=0 asynchronously forces state=IDLE, exp=15, tc_pulse=0, wrap_cnt=0, seq_err=0, err_cnt=0.
REQ-026 rst asserted mid-period discards alignment; after release, next sample handled as from IDLE.
REQ-027 rst deassertion takes effect on the next rising clk; no sample accepted in the release cycle's preceding edge.

Configuration
REQ-028 Macro COUNT_SEQ_CHECKER_ERR_CNT_EN defined: err_cnt port and saturating counter present per REQ-012/017/021.
REQ-029 Macro undefined: err_cnt port and logic absent; all other behaviour identical.

Structure
REQ-030 Shared package holds FSM state encodings, CNT_W=4, CNT_MAX=15 constants.
REQ-031 One sub-module seq_next_val: combinational 4-bit modulo-16 decrement producing exp; instantiated once.

Verification
REQ-032 Reset then cnt_vld each cycle with 15,14..0 -> state TRACK from first sample, tc_pulse once after 0, wrap_cnt=1, seq_err=0.
REQ-033 Samples 7,6,5 then 15..0 -> SYNC for first three, no seq_err, wrap_cnt=1.
REQ-034 Aligned 15,14,12 -> FAULT after 12, seq_err=1, err_cnt=1; then 15..0 -> TRACK, tc_pulse, wrap_cnt=1, seq_err stays 1.
REQ-035 Two full periods with cnt_vld gaps of 3 idle cycles between samples -> wrap_cnt=2, no error, no tc_pulse in gaps.
REQ-036 rst=0 mid-period at sample 8 (async, between edges) -> outputs zero immediately; resume at 7 -> SYNC, no error.
REQ-037 clr with cnt_vld and sample 0 same cycle in TRACK -> no tc_pulse, wrap_cnt=0, state IDLE.
